minesweeper_game_ctrl: RTL and testbench
========================================

// Module: minesweeper_game_ctrl
// PURPOSE
//   Game-play controller for the 8x8 board. Takes debounced single-cycle player commands and the
//   mine map, and owns the cursor, flag and step maps that the gameboard renderer draws
//   (posMap/flagMap/stepMap). Performs zero-cell flood reveal and win/loss detection. Sits
//   directly upstream of the gameboard renderer and replaces manual loading of those three maps.
// PARAMETERS
//   ROWS       8   board rows; N = ROWS*COLS map bits
//   COLS       8   board columns
//   START_POS  0   cursor cell index after reset / new_game
// PORTS
//   clk         in   1  system clock (CLOCK_50)
//   reset       in   1  asynchronous, active-high reset
//   new_game    in   1  1-cycle pulse: clear maps, restart play
//   move_up     in   1  1-cycle pulse: cursor row-1
//   move_down   in   1  1-cycle pulse: cursor row+1
//   move_left   in   1  1-cycle pulse: cursor col-1
//   move_right  in   1  1-cycle pulse: cursor col+1
//   flag        in   1  1-cycle pulse: toggle flag at cursor
//   step        in   1  1-cycle pulse: uncover cell at cursor
//   mineMap     in   N  1 = mine; held stable by loader while busy
//   posMap      out  N  one-hot cursor position
//   flagMap     out  N  1 = flagged
//   stepMap     out  N  1 = uncovered
//   adj_count   out  4  mines in 8 neighbours of cursor cell (0..8)
//   busy        out  1  high in REVEAL/CHECK; commands ignored
//   map_update  out  1  1-cycle pulse after any map register changes (renderer redraw)
//   game_lost   out  1  high in LOST
//   game_won    out  1  high in WON
// BEHAVIOUR
//   - Cell index i = row*COLS + col; row 0 top, col 0 left.
//   - Reset: posMap = 1<<START_POS, flagMap = stepMap = 0, adj_count = count at START_POS after
//     1st clk (0 during reset), busy = map_update = game_lost = game_won = 0, state PLAY.
//   - States: PLAY, REVEAL, CHECK, LOST, WON.
//   - PLAY, one command per cycle, priority step > flag > up > down > left > right; lower ones
//     that cycle are dropped, not queued.
//   - Moves saturate at board edges (no wrap); a saturated move changes nothing, no map_update.
//   - flag: toggles flagMap[cur] only if stepMap[cur]=0; else ignored.
//   - step: ignored if flagMap[cur] or stepMap[cur]. Else stepMap[cur]<=1 and next state:
//     mineMap[cur] -> LOST; adjacent-mine count of cur == 0 -> REVEAL; otherwise -> CHECK.
//   - REVEAL: sweep idx 0..N-1, one cell per clk. Cell idx is set in stepMap when unstepped,
//     unflagged, non-mine and adjacent (8-neighbour, edge-clipped) to a stepped cell of zero
//     count; updates visible to later cells in the same pass. Pass end: if any cell set,
//     restart at idx 0, else -> CHECK. Passes cost N clks each; worst case bounded by N passes.
//   - CHECK (1 clk): (stepMap | mineMap) all ones -> WON, else -> PLAY.
//   - busy = (state==REVEAL || state==CHECK).
//   - LOST/WON: all commands except new_game ignored; game_lost / game_won held high.
//   - new_game in any state (incl. mid-REVEAL, which aborts): next clk flagMap = stepMap = 0,
//     posMap = 1<<START_POS, state PLAY, flags low; beats every other command that cycle.
//   - adj_count: registered; equals neighbour mine count of the cursor cell one clk after
//     posMap or mineMap changes; 4-bit unsigned, max 8.
//   - map_update: asserted exactly the clk after any of posMap/flagMap/stepMap changed
//     (one pulse per changing edge; continuous during a REVEAL pass that keeps setting cells).
//   - Reset mid-operation: asynchronous return to reset values, REVEAL progress discarded.
// TESTING
//   - Reset, move_left x3, move_up x2 -> posMap=64'h1, no map_update; move_right -> posMap=64'h2.
//   - mineMap=0, step at cell 0 -> REVEAL; ~64-128 clks later stepMap=all ones, game_won=1.
//   - mineMap bit 9 set, cursor 0, step -> stepMap=64'h1, adj_count=1, CHECK then PLAY.
//   - flag at 9, step at 9 -> ignored; flag again -> flagMap=0; step -> game_lost=1, stepMap[9]=1.
//   - step+flag+move_right same clk at cell 3 -> only step acts, posMap stays 1<<3.
//   - new_game asserted mid-REVEAL -> next clk busy=0, stepMap=0, posMap=1<<START_POS.

Source files
------------

// File: rtl/minesweeper_game_ctrl.sv
// Game-play controller for a ROWSxCOLS minesweeper board: cursor, flag and step maps,
// zero-cell flood reveal and win/loss detection.
module minesweeper_game_ctrl #(
   parameter int ROWS      = 8,
   parameter int COLS      = 8,
   parameter int START_POS = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   new_game,
   input  logic                   move_up,
   input  logic                   move_down,
   input  logic                   move_left,
   input  logic                   move_right,
   input  logic                   flag,
   input  logic                   step,
   input  logic [ROWS*COLS-1:0]   mineMap,
   output logic [ROWS*COLS-1:0]   posMap,
   output logic [ROWS*COLS-1:0]   flagMap,
   output logic [ROWS*COLS-1:0]   stepMap,
   output logic [3:0]             adj_count,
   output logic                   busy,
   output logic                   map_update,
   output logic                   game_lost,
   output logic                   game_won
);
   localparam int N  = ROWS * COLS;
   localparam int IW = $clog2(N);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam logic [RW-1:0] START_ROW = RW'(START_POS / COLS);
   localparam logic [CW-1:0] START_COL = CW'(START_POS % COLS);

   typedef enum logic [2:0] {S_PLAY, S_REVEAL, S_CHECK, S_LOST, S_WON} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic [N-1:0]    flag_q, flag_d;
   logic [N-1:0]    step_q, step_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            any_q, any_d;
   logic [3:0]      adj_q;
   logic            upd_q;

   logic [IW-1:0]   cur_idx;
   logic [N-1:0]    zero_map;
   logic [N-1:0]    nb_zero;
   logic [3:0]      cell_cnt [N];
   logic            reveal_hit;

   // Edge-clipped 8-neighbour mask of cell (r, c); only evaluated with constant arguments.
   function automatic logic [N-1:0] nb_mask(input int r, input int c);
      logic [N-1:0] m;
      m = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < ROWS) &&
                (c + dc >= 0) && (c + dc < COLS))
               m[(r + dr) * COLS + (c + dc)] = 1'b1;
         end
      end
      return m;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cell
         localparam logic [N-1:0] NB = nb_mask(gi / COLS, gi % COLS);
         assign cell_cnt[gi] = 4'($countones(NB & mineMap));
         assign zero_map[gi] = ~|(NB & mineMap);
         assign nb_zero[gi]  = |(NB & step_q & zero_map);
      end
   endgenerate

   assign cur_idx    = IW'(row_q) * IW'(COLS) + IW'(col_q);
   assign reveal_hit = nb_zero[idx_q] & ~step_q[idx_q] & ~flag_q[idx_q] & ~mineMap[idx_q];

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      flag_d  = flag_q;
      step_d  = step_q;
      idx_d   = idx_q;
      any_d   = any_q;
      if (new_game) begin
         state_d = S_PLAY;
         row_d   = START_ROW;
         col_d   = START_COL;
         flag_d  = '0;
         step_d  = '0;
         idx_d   = '0;
         any_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_PLAY: begin
               // Only the highest-priority command acts; the rest are dropped.
               if (step) begin
                  if (!flag_q[cur_idx] && !step_q[cur_idx]) begin
                     step_d[cur_idx] = 1'b1;
                     idx_d           = '0;
                     any_d           = 1'b0;
                     if (mineMap[cur_idx])       state_d = S_LOST;
                     else if (zero_map[cur_idx]) state_d = S_REVEAL;
                     else                        state_d = S_CHECK;
                  end
               end else if (flag) begin
                  if (!step_q[cur_idx]) flag_d[cur_idx] = ~flag_q[cur_idx];
               end else if (move_up) begin
                  if (row_q != '0) row_d = row_q - 1'b1;
               end else if (move_down) begin
                  if (row_q != RW'(ROWS - 1)) row_d = row_q + 1'b1;
               end else if (move_left) begin
                  if (col_q != '0) col_d = col_q - 1'b1;
               end else if (move_right) begin
                  if (col_q != CW'(COLS - 1)) col_d = col_q + 1'b1;
               end
            end
            S_REVEAL: begin
               if (reveal_hit) step_d[idx_q] = 1'b1;
               if (idx_q == IW'(N - 1)) begin
                  idx_d = '0;
                  any_d = 1'b0;
                  if (!(any_q || reveal_hit)) state_d = S_CHECK;
               end else begin
                  idx_d = idx_q + 1'b1;
                  any_d = any_q | reveal_hit;
               end
            end
            S_CHECK: state_d = (&(step_q | mineMap)) ? S_WON : S_PLAY;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_PLAY;
         row_q   <= START_ROW;
         col_q   <= START_COL;
         flag_q  <= '0;
         step_q  <= '0;
         idx_q   <= '0;
         any_q   <= 1'b0;
         adj_q   <= '0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         flag_q  <= flag_d;
         step_q  <= step_d;
         idx_q   <= idx_d;
         any_q   <= any_d;
         adj_q   <= cell_cnt[cur_idx];
         upd_q   <= (row_d != row_q) || (col_d != col_q) ||
                    (flag_d != flag_q) || (step_d != step_q);
      end
   end

   assign posMap     = {{(N-1){1'b0}}, 1'b1} << cur_idx;
   assign flagMap    = flag_q;
   assign stepMap    = step_q;
   assign adj_count  = adj_q;
   assign busy       = (state_q == S_REVEAL) || (state_q == S_CHECK);
   assign map_update = upd_q;
   assign game_lost  = (state_q == S_LOST);
   assign game_won   = (state_q == S_WON);
endmodule

// File: tb/tb_minesweeper_game_ctrl.sv
// Directed bench for minesweeper_game_ctrl: moves, flags, steps, flood reveal, abort, win/loss.
module tb_minesweeper_game_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        new_game, move_up, move_down, move_left, move_right, flag, step;
   logic [63:0] mineMap, posMap, flagMap, stepMap;
   logic [3:0]  adj_count;
   logic        busy, map_update, game_lost, game_won;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   minesweeper_game_ctrl #(.ROWS(8), .COLS(8), .START_POS(0)) dut (
      .clk(clk), .reset(reset), .new_game(new_game),
      .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
      .flag(flag), .step(step), .mineMap(mineMap),
      .posMap(posMap), .flagMap(flagMap), .stepMap(stepMap), .adj_count(adj_count),
      .busy(busy), .map_update(map_update), .game_lost(game_lost), .game_won(game_won)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
         $display("check %-14s ok  value=%h", tag, obs);
      end else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive for one posedge, release at the next negedge.
   task automatic pulse(input int which);
      case (which)
         0: new_game   = 1'b1;
         1: move_up    = 1'b1;
         2: move_down  = 1'b1;
         3: move_left  = 1'b1;
         4: move_right = 1'b1;
         5: flag       = 1'b1;
         default: step = 1'b1;
      endcase
      @(negedge clk);
      {new_game, move_up, move_down, move_left, move_right, flag, step} = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      for (int i = 0; i < limit && busy; i++) @(negedge clk);
      chk(tag, {63'd0, busy}, 64'd0);
   endtask

   localparam int NG = 0, UP = 1, DN = 2, LT = 3, RT = 4, FL = 5, ST = 6;

   initial begin
      reset = 1'b1;
      {new_game, move_up, move_down, move_left, move_right, flag, step} = '0;
      mineMap = '0;
      #12;
      chk("rst_pos",   posMap, 64'h1);
      chk("rst_flag",  flagMap, 64'h0);
      chk("rst_step",  stepMap, 64'h0);
      chk("rst_adj",   {60'd0, adj_count}, 64'd0);
      chk("rst_flags", {60'd0, busy, map_update, game_lost, game_won}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      idle(1);
      chk("adj0_empty", {60'd0, adj_count}, 64'd0);

      // Saturated moves at the top-left corner.
      for (int i = 0; i < 5; i++) begin
         pulse(i < 3 ? LT : UP);
         chk("sat_pos", posMap, 64'h1);
         chk("sat_upd", {63'd0, map_update}, 64'd0);
      end
      pulse(RT);
      chk("right_pos", posMap, 64'h2);
      chk("right_upd", {63'd0, map_update}, 64'd1);
      idle(1);
      chk("upd_pulse", {63'd0, map_update}, 64'd0);

      // Mine at 9: step at 0 has count 1 -> CHECK -> PLAY.
      mineMap = 64'h1 << 9;
      pulse(LT);
      idle(1);
      chk("adj0_mine9", {60'd0, adj_count}, 64'd1);
      pulse(ST);
      chk("step0_map",  stepMap, 64'h1);
      chk("step0_busy", {63'd0, busy}, 64'd1);
      idle(1);
      chk("check_done", {62'd0, busy, game_won}, 64'd0);

      // Flag blocks step on the mine; unflag then step loses.
      pulse(DN);
      pulse(RT);
      chk("pos9", posMap, 64'h1 << 9);
      pulse(FL);
      chk("flag9", flagMap, 64'h1 << 9);
      pulse(ST);
      chk("step_flagged", stepMap, 64'h1);
      idle(1);
      chk("adj9", {60'd0, adj_count}, 64'd0);
      pulse(FL);
      chk("unflag9", flagMap, 64'h0);
      pulse(ST);
      chk("lost", {63'd0, game_lost}, 64'd1);
      chk("lost_step", stepMap, 64'h201);
      pulse(RT);
      chk("lost_nomove", posMap, 64'h1 << 9);
      chk("lost_hold", {63'd0, game_lost}, 64'd1);

      pulse(NG);
      chk("ng_step", stepMap, 64'h0);
      chk("ng_pos",  posMap, 64'h1);
      chk("ng_lost", {63'd0, game_lost}, 64'd0);
      chk("ng_upd",  {63'd0, map_update}, 64'd1);

      // Simultaneous step+flag+right at cell 3: only step acts (zero cell -> REVEAL).
      for (int i = 0; i < 3; i++) pulse(RT);
      step = 1'b1; flag = 1'b1; move_right = 1'b1;
      @(negedge clk);
      {step, flag, move_right} = '0;
      chk("prio_pos",  posMap, 64'h8);
      chk("prio_flag", flagMap, 64'h0);
      chk("prio_step", stepMap, 64'h8);
      chk("prio_busy", {63'd0, busy}, 64'd1);
      idle(5);
      chk("reveal_busy", {63'd0, busy}, 64'd1);
      pulse(NG);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_step", stepMap, 64'h0);
      chk("abort_pos",  posMap, 64'h1);

      // Full flood from cell 3 with a mine at 9: cells 0,1,8 stay covered.
      for (int i = 0; i < 3; i++) pulse(RT);
      pulse(ST);
      wait_idle("flood9_tmo", 10000);
      chk("flood9_map", stepMap, 64'hFFFF_FFFF_FFFF_FCFC);
      chk("flood9_end", {62'd0, game_lost, game_won}, 64'd0);

      // Empty board: one step reveals everything and wins.
      pulse(NG);
      mineMap = '0;
      pulse(ST);
      wait_idle("win_tmo", 1000);
      chk("win_map",  stepMap, {64{1'b1}});
      chk("win_flag", {63'd0, game_won}, 64'd1);
      pulse(RT);
      chk("won_nomove", posMap, 64'h1);

      // Mine in the far corner: everything else uncovered, still a win.
      pulse(NG);
      mineMap = 64'h1 << 63;
      pulse(ST);
      wait_idle("corner_tmo", 10000);
      chk("corner_map", stepMap, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("corner_won", {63'd0, game_won}, 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
